evm_booth_arbiter: RTL and testbench
====================================

# evm_booth_arbiter

Shares the single EVM vote-tally datapath between `NUM_BOOTHS` voting booths. Each booth presents a voter UID and a one-hot candidate selection; the block grants booths round-robin, validates the request, and issues exactly one increment pulse to the tally. It rejects double votes using a per-UID voted roll. It sits between the booth front-ends and the existing control/tally unit.

## Interface
- `NUM_BOOTHS`, 4: number of requesting booths, 2..8.
- `UID_W`, 6: voter UID width; the roll holds 2^UID_W entries.
- `NUM_CAND`, 4: number of candidates; selections are one-hot.
- `CNT_W`, 8: width of the accepted and rejected counters.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: **asynchronous, active-low** reset.
- `mode` in 1: 1 = voting open; 0 = closed, no new grants.
- `clear_roll` in 1: clears the voted roll; honoured only when `mode`=0 and the FSM is in IDLE.
- `req_valid` in NUM_BOOTHS: per-booth request.
- `req_uid` in NUM_BOOTHS*UID_W: booth b's UID in bits [b*UID_W +: UID_W].
- `req_cand` in NUM_BOOTHS*NUM_CAND: booth b's selection in bits [b*NUM_CAND +: NUM_CAND].
- `req_ready` out NUM_BOOTHS: one-hot grant pulse; the request is captured on this cycle.
- `rsp_valid` out NUM_BOOTHS: one-cycle response pulse to the granted booth.
- `rsp_code` out 2: 0 OK, 1 DUPLICATE, 2 BAD_UID, 3 BAD_CAND; valid only while `rsp_valid` is high.
- `tally_busy` in 1: tally cannot accept an increment this cycle.
- `tally_inc` out NUM_CAND: one-hot one-cycle increment to the tally.
- `total_accepted` out CNT_W: saturating count of accepted votes.
- `total_rejected` out CNT_W: saturating count of rejected requests.
- `busy` out 1: FSM is not in IDLE.
- `vvpat_cand` out NUM_CAND: last accepted selection (see Configuration).
- `vvpat_booth` out $clog2(NUM_BOOTHS): booth that cast the last accepted vote.

## Operation
- FSM states: IDLE, CHECK, COMMIT, RESP.
- **IDLE**
  - If `mode`=1 and any `req_valid` is high, grant one booth round-robin and assert its `req_ready` for one cycle.
  - Capture that booth's UID and selection, then go to CHECK.
- **CHECK**
  - UID==0 → BAD_UID.
  - Otherwise, selection not exactly one-hot → BAD_CAND.
  - Otherwise, roll[UID] already set → DUPLICATE.
  - Any reject code goes to RESP. A clean request goes to COMMIT.
- **COMMIT**
  - Wait while `tally_busy`=1.
  - On the first cycle with `tally_busy`=0: pulse `tally_inc` = selection, set roll[UID], increment `total_accepted`, go to RESP.
- **RESP**
  - Pulse `rsp_valid` for the granted booth with `rsp_code`.
  - Increment `total_rejected` if the code is non-zero, then return to IDLE.
- **Round robin:** priority starts at booth (last_granted+1) mod NUM_BOOTHS. After reset, last_granted = NUM_BOOTHS-1, so booth 0 has highest priority.
- **Mode changes:** `mode` falling mid-transaction does not abort; the transaction completes. The check on `mode` applies only at grant.
- **Counters:** both saturate at 2^CNT_W-1 and never wrap.
- **Simultaneous events:** a booth that deasserts `req_valid` after its grant still receives its response. The same UID requested from two booths back-to-back gives the first OK and the second DUPLICATE.
- **Reset:** asserting `reset` at any time, including mid-operation, immediately returns the FSM to IDLE. It clears the roll, both counters, the VVPAT registers and the arbiter pointer. Any in-flight vote is lost and no response is issued.

## Timing
- Reset values: every output is 0. `busy`=0.
- Accepted request with `tally_busy`=0:
  - `req_ready` in cycle T.
  - `tally_inc` in T+2.
  - `rsp_valid` in T+3.
  - Next grant no earlier than T+4.
- Each cycle of `tally_busy`=1 in COMMIT adds one cycle.
- Rejected request: `req_ready` in T, `rsp_valid` in T+2, next grant no earlier than T+3.
- At most one `req_ready`, one `rsp_valid` and one `tally_inc` bit are high in any cycle.
- `total_accepted` updates on the cycle after `tally_inc`. `total_rejected` updates on the cycle after `rsp_valid`.

## Configuration
- `EVM_VVPAT_EN` defined:
  - On each commit, `vvpat_cand` and `vvpat_booth` load the selection and booth.
  - They hold until the next commit or reset.
- `EVM_VVPAT_EN` undefined:
  - The VVPAT registers are not built.
  - `vvpat_cand` and `vvpat_booth` are tied to 0.
  - All other behaviour is identical.

## Structure
- Package `evm_pkg`:
  - FSM state enum.
  - `rsp_code` constants RSP_OK, RSP_DUP, RSP_BAD_UID, RSP_BAD_CAND.
  - UID 0 reserved constant.
- Sub-module `evm_rr_arbiter`:
  - Parameterised by NUM_BOOTHS.
  - Inputs: request vector and enable.
  - Outputs: one-hot grant and the registered pointer.
- The roll is a 2^UID_W-bit register vector inside `evm_booth_arbiter`.

## Test plan
- **Single vote:** after reset, booth 0 sends UID 0x02 with selection 0001 → `tally_inc`=0001 at T+2, rsp OK at T+3, `total_accepted`=1.
- **Double vote:** UID 0x02 again from booth 2 → DUPLICATE, no `tally_inc`, `total_rejected`=1.
- **Round robin:** booths 0..3 all request with unique UIDs 0x11, 0x13, 0x15, 0x3C → grants in order 0,1,2,3 and four OK responses.
- **Invalid inputs:**
  - UID 0x00 → BAD_UID.
  - Selection 0101 → BAD_CAND.
  - Selection 0000 → BAD_CAND.
  - Counters unchanged except `total_rejected`.
- **Tally stall:** `tally_busy` held high for 5 cycles during COMMIT → `tally_inc` is delayed exactly 5 cycles. Dropping `mode` to 0 in the same window still completes the vote, and no further grants follow.
- **Mid-operation reset:** `reset` low in COMMIT → all outputs 0 and the roll is cleared. Resubmitting the same UID is then accepted. With `EVM_VVPAT_EN` defined, `vvpat_cand` shows the new vote.

Source files
------------

// File: rtl/evm_pkg.sv
// -----------------------------------------------------------------------------
// evm_pkg
// Shared types and constants for the EVM booth arbiter slice.
//   evm_state_e  : transaction FSM states (IDLE, CHECK, COMMIT, RESP)
//   RSP_*        : response codes driven on rsp_code
//   UID_RESERVED : voter UID that is never valid
//   is_one_hot() : true when exactly one bit of the (zero-extended) value is set
// -----------------------------------------------------------------------------
package evm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_RESP   = 2'd3
   } evm_state_e;

   localparam logic [1:0] RSP_OK       = 2'd0;
   localparam logic [1:0] RSP_DUP      = 2'd1;
   localparam logic [1:0] RSP_BAD_UID  = 2'd2;
   localparam logic [1:0] RSP_BAD_CAND = 2'd3;

   localparam int unsigned UID_RESERVED = 0;

   // Callers zero-extend their selection to 32 bits (NUM_CAND <= 32).
   function automatic logic is_one_hot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/evm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// evm_rr_arbiter
// Round-robin grant generator for NUM_BOOTHS requesters.
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset (pointer returns to NUM_BOOTHS-1)
//   enable : allow a grant this cycle
//   req    : per-booth request vector
//   grant  : one-hot grant (combinational, zero when disabled or idle)
//   ptr    : registered index of the most recently granted booth
// Priority begins at (ptr+1) mod NUM_BOOTHS, so booth 0 wins first after reset.
// -----------------------------------------------------------------------------
module evm_rr_arbiter #(
   parameter  int NUM_BOOTHS = 4,
   localparam int PTR_W      = $clog2(NUM_BOOTHS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NUM_BOOTHS-1:0] req,
   output logic [NUM_BOOTHS-1:0] grant,
   output logic [PTR_W-1:0]      ptr
);

   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] scan_idx;
   logic             win_found;

   // Scan from the booth after the last winner; first requester found wins.
   always_comb begin
      grant     = '0;
      win_idx   = ptr_reg;
      win_found = 1'b0;
      scan_idx  = '0;
      for (int i = 1; i <= NUM_BOOTHS; i++) begin
         scan_idx = PTR_W'((int'(ptr_reg) + i) % NUM_BOOTHS);
         if (enable && !win_found && req[scan_idx]) begin
            win_found       = 1'b1;
            win_idx         = scan_idx;
            grant[scan_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_reg <= PTR_W'(NUM_BOOTHS - 1);
      end else if (win_found) begin
         ptr_reg <= win_idx;
      end
   end

   assign ptr = ptr_reg;

endmodule

// File: rtl/evm_booth_arbiter.sv
// -----------------------------------------------------------------------------
// evm_booth_arbiter
// Shares the single EVM tally datapath between NUM_BOOTHS voting booths.
// A booth is granted round-robin, its request is validated (reserved UID,
// one-hot selection, voted roll) and a clean vote produces exactly one
// tally_inc pulse. Every granted request receives one rsp_valid pulse.
//
// Ports:
//   clock, reset            : rising-edge clock, asynchronous active-low reset
//   mode                    : 1 = voting open (grants allowed)
//   clear_roll              : clears the voted roll when mode=0 and idle
//   req_valid/uid/cand      : packed per-booth requests
//   req_ready               : one-hot grant pulse (request captured that cycle)
//   rsp_valid, rsp_code     : one-cycle response to the granted booth
//   tally_busy, tally_inc   : tally back-pressure and one-hot increment pulse
//   total_accepted/rejected : saturating vote counters
//   busy                    : transaction in progress
//   vvpat_cand, vvpat_booth : last accepted selection and booth
//
// Build option: define EVM_VVPAT_EN to build the VVPAT registers; otherwise
// vvpat_cand and vvpat_booth are tied to zero.
// -----------------------------------------------------------------------------
module evm_booth_arbiter
   import evm_pkg::*;
#(
   parameter  int NUM_BOOTHS = 4,
   parameter  int UID_W      = 6,
   parameter  int NUM_CAND   = 4,
   parameter  int CNT_W      = 8,
   localparam int BOOTH_W    = $clog2(NUM_BOOTHS)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           mode,
   input  logic                           clear_roll,
   input  logic [NUM_BOOTHS-1:0]          req_valid,
   input  logic [NUM_BOOTHS*UID_W-1:0]    req_uid,
   input  logic [NUM_BOOTHS*NUM_CAND-1:0] req_cand,
   output logic [NUM_BOOTHS-1:0]          req_ready,
   output logic [NUM_BOOTHS-1:0]          rsp_valid,
   output logic [1:0]                     rsp_code,
   input  logic                           tally_busy,
   output logic [NUM_CAND-1:0]            tally_inc,
   output logic [CNT_W-1:0]               total_accepted,
   output logic [CNT_W-1:0]               total_rejected,
   output logic                           busy,
   output logic [NUM_CAND-1:0]            vvpat_cand,
   output logic [BOOTH_W-1:0]             vvpat_booth
);

   evm_state_e            state_reg;
   logic [UID_W-1:0]      uid_reg;
   logic [NUM_CAND-1:0]   cand_reg;
   logic [1:0]            code_reg;
   logic [2**UID_W-1:0]   roll_reg;
   logic [CNT_W-1:0]      acc_reg;
   logic [CNT_W-1:0]      rej_reg;

   logic [NUM_BOOTHS-1:0] grant;
   logic [BOOTH_W-1:0]    booth_ptr;
   logic                  arb_en;
   logic                  commit_fire;
   logic [UID_W-1:0]      uid_sel;
   logic [NUM_CAND-1:0]   cand_sel;
   logic [UID_W-1:0]      uid_masked  [NUM_BOOTHS];
   logic [NUM_CAND-1:0]   cand_masked [NUM_BOOTHS];

   // Gating with reset keeps req_ready low while reset is held.
   assign arb_en      = reset && mode && (state_reg == ST_IDLE);
   assign commit_fire = (state_reg == ST_COMMIT) && !tally_busy;

   // The arbiter pointer doubles as the index of the booth being served:
   // it is loaded with the winner on the same edge the request is captured.
   evm_rr_arbiter #(
      .NUM_BOOTHS (NUM_BOOTHS)
   ) u_rr (
      .clock  (clock),
      .reset  (reset),
      .enable (arb_en),
      .req    (req_valid),
      .grant  (grant),
      .ptr    (booth_ptr)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BOOTHS; gi++) begin : g_booth
         assign uid_masked[gi]  = grant[gi] ? req_uid[gi*UID_W +: UID_W] : '0;
         assign cand_masked[gi] = grant[gi] ? req_cand[gi*NUM_CAND +: NUM_CAND] : '0;
         assign rsp_valid[gi]   = (state_reg == ST_RESP) && (booth_ptr == BOOTH_W'(gi));
      end
   endgenerate

   // Grant is one-hot, so OR-ing the masked fields selects the winner.
   always_comb begin
      uid_sel  = '0;
      cand_sel = '0;
      for (int b = 0; b < NUM_BOOTHS; b++) begin
         uid_sel  = uid_sel | uid_masked[b];
         cand_sel = cand_sel | cand_masked[b];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         uid_reg   <= '0;
         cand_reg  <= '0;
         code_reg  <= RSP_OK;
         roll_reg  <= '0;
         acc_reg   <= '0;
         rej_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (|grant) begin
                  uid_reg   <= uid_sel;
                  cand_reg  <= cand_sel;
                  state_reg <= ST_CHECK;
               end else if (!mode && clear_roll) begin
                  roll_reg <= '0;
               end
            end
            ST_CHECK: begin
               // Check order sets precedence: UID, then selection, then roll.
               if (uid_reg == UID_W'(UID_RESERVED)) begin
                  code_reg  <= RSP_BAD_UID;
                  state_reg <= ST_RESP;
               end else if (!is_one_hot(32'(cand_reg))) begin
                  code_reg  <= RSP_BAD_CAND;
                  state_reg <= ST_RESP;
               end else if (roll_reg[uid_reg]) begin
                  code_reg  <= RSP_DUP;
                  state_reg <= ST_RESP;
               end else begin
                  code_reg  <= RSP_OK;
                  state_reg <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               if (!tally_busy) begin
                  roll_reg[uid_reg] <= 1'b1;
                  if (acc_reg != '1) begin
                     acc_reg <= acc_reg + 1'b1;
                  end
                  state_reg <= ST_RESP;
               end
            end
            ST_RESP: begin
               if ((code_reg != RSP_OK) && (rej_reg != '1)) begin
                  rej_reg <= rej_reg + 1'b1;
               end
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign req_ready      = grant;
   assign rsp_code       = (state_reg == ST_RESP) ? code_reg : RSP_OK;
   assign tally_inc      = commit_fire ? cand_reg : '0;
   assign total_accepted = acc_reg;
   assign total_rejected = rej_reg;
   assign busy           = (state_reg != ST_IDLE);

`ifdef EVM_VVPAT_EN
   logic [NUM_CAND-1:0] vvpat_cand_reg;
   logic [BOOTH_W-1:0]  vvpat_booth_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vvpat_cand_reg  <= '0;
         vvpat_booth_reg <= '0;
      end else if (commit_fire) begin
         vvpat_cand_reg  <= cand_reg;
         vvpat_booth_reg <= booth_ptr;
      end
   end

   assign vvpat_cand  = vvpat_cand_reg;
   assign vvpat_booth = vvpat_booth_reg;
`else
   assign vvpat_cand  = '0;
   assign vvpat_booth = '0;
`endif

endmodule

// File: tb/tb_evm_booth_arbiter.sv
// -----------------------------------------------------------------------------
// tb_evm_booth_arbiter
// Self-checking bench for evm_booth_arbiter. Expected behaviour comes from a
// small reference model (voted-roll array, counters, round-robin pointer)
// built from the rules of the block. A negedge monitor logs grants, tally
// pulses and responses with cycle stamps; each test task checks its log.
// -----------------------------------------------------------------------------
module tb_evm_booth_arbiter;

   localparam int NB = 4;
   localparam int UW = 6;
   localparam int NC = 4;
   localparam int CW = 8;
   localparam int BW = 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              mode = 1'b0;
   logic              clear_roll = 1'b0;
   logic [NB-1:0]     req_valid = '0;
   logic [NB*UW-1:0]  req_uid = '0;
   logic [NB*NC-1:0]  req_cand = '0;
   logic              tally_busy = 1'b0;
   logic [NB-1:0]     req_ready;
   logic [NB-1:0]     rsp_valid;
   logic [1:0]        rsp_code;
   logic [NC-1:0]     tally_inc;
   logic [CW-1:0]     total_accepted;
   logic [CW-1:0]     total_rejected;
   logic              busy;
   logic [NC-1:0]     vvpat_cand;
   logic [BW-1:0]     vvpat_booth;

   evm_booth_arbiter #(
      .NUM_BOOTHS (NB),
      .UID_W      (UW),
      .NUM_CAND   (NC),
      .CNT_W      (CW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .mode           (mode),
      .clear_roll     (clear_roll),
      .req_valid      (req_valid),
      .req_uid        (req_uid),
      .req_cand       (req_cand),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_code       (rsp_code),
      .tally_busy     (tally_busy),
      .tally_inc      (tally_inc),
      .total_accepted (total_accepted),
      .total_rejected (total_rejected),
      .busy           (busy),
      .vvpat_cand     (vvpat_cand),
      .vvpat_booth    (vvpat_booth)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int passed = 0;

   // ---------------- reference model ----------------
   bit model_roll [2**UW];
   int model_acc;
   int model_rej;
   int model_ptr;

   function automatic void model_reset();
      for (int i = 0; i < 2**UW; i++) model_roll[i] = 1'b0;
      model_acc = 0;
      model_rej = 0;
      model_ptr = NB - 1;
   endfunction

   function automatic logic [1:0] model_code(input logic [UW-1:0] uid, input logic [NC-1:0] cand);
      if (uid == 0) return 2'd2;
      if ($countones(cand) != 1) return 2'd3;
      if (model_roll[uid]) return 2'd1;
      return 2'd0;
   endfunction

   // Pick the next winner among pend and advance the pointer.
   function automatic int model_grant(input logic [NB-1:0] pend);
      for (int i = 1; i <= NB; i++) begin
         int idx;
         idx = (model_ptr + i) % NB;
         if (pend[idx]) begin
            model_ptr = idx;
            return idx;
         end
      end
      return -1;
   endfunction

   function automatic void model_apply(input logic [1:0] code, input logic [UW-1:0] uid);
      if (code == 2'd0) begin
         model_roll[uid] = 1'b1;
         if (model_acc < CNT_MAX) model_acc++;
      end else begin
         if (model_rej < CNT_MAX) model_rej++;
      end
   endfunction

   // ---------------- event monitor ----------------
   int            cyc = 0;
   int            g_cyc [$];
   logic [NB-1:0] g_vec [$];
   int            t_cyc [$];
   logic [NC-1:0] t_val [$];
   int            r_cyc [$];
   logic [NB-1:0] r_vec [$];
   logic [1:0]    r_code [$];
   int            multi_err = 0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (req_ready != '0) begin g_cyc.push_back(cyc); g_vec.push_back(req_ready); end
      if (tally_inc != '0) begin t_cyc.push_back(cyc); t_val.push_back(tally_inc); end
      if (rsp_valid != '0) begin r_cyc.push_back(cyc); r_vec.push_back(rsp_valid); r_code.push_back(rsp_code); end
      if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1 || $countones(tally_inc) > 1) multi_err++;
   end

   task automatic clear_mon();
      g_cyc.delete(); g_vec.delete();
      t_cyc.delete(); t_val.delete();
      r_cyc.delete(); r_vec.delete(); r_code.delete();
   endtask

   task automatic set_req(input int b, input logic [UW-1:0] uid, input logic [NC-1:0] cand);
      req_uid[b*UW +: UW]  = uid;
      req_cand[b*NC +: NC] = cand;
   endtask

   task automatic apply_reset();
      reset = 1'b0; mode = 1'b0; req_valid = '0; tally_busy = 1'b0; clear_roll = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      model_reset();
   endtask

   // One request from booth b; tally_busy held for k cycles of COMMIT.
   task automatic run_one(input int b, input logic [UW-1:0] uid, input logic [NC-1:0] cand,
                          input int k, output int tg, output bit ok);
      clear_mon();
      @(posedge clock); #1;
      set_req(b, uid, cand);
      req_valid = '0; req_valid[b] = 1'b1;
      mode = 1'b1;
      tally_busy = (k > 0);
      ok = 1'b0; tg = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); #1;
         if (g_cyc.size() != 0) begin ok = 1'b1; break; end
      end
      if (!ok) begin req_valid = '0; tally_busy = 1'b0; return; end
      tg = g_cyc[0];
      @(posedge clock); #1 req_valid = '0;
      if (k > 0) begin
         repeat (1 + k) @(posedge clock);
         #1 tally_busy = 1'b0;
      end
      for (int i = 0; i < 20 && r_cyc.size() == 0; i++) begin @(negedge clock); #1; end
      if (r_cyc.size() == 0) ok = 1'b0;
      repeat (2) @(posedge clock);
      #1;
   endtask

   // Serve every pending request already driven on req_valid.
   task automatic serve(input bit rand_busy, output bit ok);
      logic [NB-1:0] gv;
      ok = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clock); #1; gv = req_ready;
         @(posedge clock); #1;
         req_valid = req_valid & ~gv;
         if (rand_busy) tally_busy = ($urandom_range(0, 2) == 0);
         if (req_valid == '0 && !busy) begin ok = 1'b1; break; end
      end
      tally_busy = 1'b0;
      req_valid = '0;
      @(posedge clock); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0; mode = 1'b1; req_valid = '1; tally_busy = 1'b0;
      for (int b = 0; b < NB; b++) set_req(b, UW'(b + 1), 4'b0001);
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++; if (req_ready !== '0) $display("FAIL reset_req_ready got %b exp 0", req_ready); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
      req_valid = '0; mode = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      model_reset();
      @(negedge clock);
      checks++; if (rsp_valid !== '0 || rsp_code !== 2'd0) $display("FAIL reset_rsp got %b/%0d exp 0/0", rsp_valid, rsp_code); else passed++;
      checks++; if (tally_inc !== '0) $display("FAIL reset_tally got %b exp 0", tally_inc); else passed++;
      checks++; if (total_accepted !== '0 || total_rejected !== '0) $display("FAIL reset_counters got %0d/%0d exp 0/0", total_accepted, total_rejected); else passed++;
      checks++; if (vvpat_cand !== '0 || vvpat_booth !== '0) $display("FAIL reset_vvpat got %b/%0d exp 0/0", vvpat_cand, vvpat_booth); else passed++;
   endtask

   task automatic test_single_vote();
      int tg; bit ok; logic [1:0] ec; int eb;
      logic [NC-1:0] evc; logic [BW-1:0] evb;
      eb = model_grant(4'b0001);
      ec = model_code(6'h02, 4'b0001);
      model_apply(ec, 6'h02);
      run_one(0, 6'h02, 4'b0001, 0, tg, ok);
      checks++; if (!ok) $display("FAIL single_done got timeout exp response"); else passed++;
      checks++; if (g_vec[0] !== NB'(1 << eb)) $display("FAIL single_grant got %b exp booth %0d", g_vec[0], eb); else passed++;
      checks++; if (t_cyc.size() != 1 || t_cyc[0] - tg != 2 || t_val[0] !== 4'b0001) $display("FAIL single_tally got n=%0d dt=%0d val=%b exp n=1 dt=2 val=0001", t_cyc.size(), t_cyc[0] - tg, t_val[0]); else passed++;
      checks++; if (r_cyc[0] - tg != 3 || r_vec[0] !== 4'b0001 || r_code[0] !== ec) $display("FAIL single_rsp got dt=%0d vec=%b code=%0d exp dt=3 vec=0001 code=%0d", r_cyc[0] - tg, r_vec[0], r_code[0], ec); else passed++;
      checks++; if (total_accepted !== CW'(model_acc) || total_rejected !== CW'(model_rej)) $display("FAIL single_counters got %0d/%0d exp %0d/%0d", total_accepted, total_rejected, model_acc, model_rej); else passed++;
`ifdef EVM_VVPAT_EN
      evc = 4'b0001; evb = 2'd0;
`else
      evc = '0; evb = '0;
`endif
      checks++; if (vvpat_cand !== evc || vvpat_booth !== evb) $display("FAIL single_vvpat got %b/%0d exp %b/%0d", vvpat_cand, vvpat_booth, evc, evb); else passed++;
   endtask

   task automatic test_double_vote();
      int tg; bit ok; logic [1:0] ec; int eb;
      eb = model_grant(4'b0100);
      ec = model_code(6'h02, 4'b0010);
      model_apply(ec, 6'h02);
      run_one(2, 6'h02, 4'b0010, 0, tg, ok);
      checks++; if (!ok || g_vec[0] !== NB'(1 << eb)) $display("FAIL double_grant got %b ok=%0d exp booth %0d", g_vec[0], ok, eb); else passed++;
      checks++; if (r_code[0] !== ec || ec !== 2'd1 || r_cyc[0] - tg != 2) $display("FAIL double_rsp got code=%0d dt=%0d exp code=1 dt=2", r_code[0], r_cyc[0] - tg); else passed++;
      checks++; if (t_cyc.size() != 0) $display("FAIL double_no_tally got %0d pulses exp 0", t_cyc.size()); else passed++;
      checks++; if (total_accepted !== CW'(model_acc) || total_rejected !== CW'(model_rej)) $display("FAIL double_counters got %0d/%0d exp %0d/%0d", total_accepted, total_rejected, model_acc, model_rej); else passed++;
   endtask

   task automatic test_round_robin();
      logic [UW-1:0] u [NB];
      logic [NC-1:0] c [NB];
      logic [NB-1:0] pend;
      logic [1:0]    ec;
      bit ok; int eb;
      apply_reset();
      u[0] = 6'h11; u[1] = 6'h13; u[2] = 6'h15; u[3] = 6'h3C;
      clear_mon();
      @(posedge clock); #1;
      for (int b = 0; b < NB; b++) begin
         c[b] = NC'(1 << $urandom_range(0, NC - 1));
         set_req(b, u[b], c[b]);
      end
      mode = 1'b1; req_valid = '1;
      serve(1'b0, ok);
      checks++; if (!ok || g_cyc.size() != NB) $display("FAIL rr_count got %0d grants ok=%0d exp %0d", g_cyc.size(), ok, NB); else passed++;
      pend = '1;
      for (int i = 0; i < NB; i++) begin
         eb = model_grant(pend);
         pend[eb] = 1'b0;
         ec = model_code(u[eb], c[eb]);
         model_apply(ec, u[eb]);
         checks++; if (g_vec[i] !== NB'(1 << eb) || eb != i) $display("FAIL rr_order[%0d] got %b exp booth %0d", i, g_vec[i], eb); else passed++;
         checks++; if (r_code[i] !== ec || ec !== 2'd0 || t_val[i] !== c[eb]) $display("FAIL rr_rsp[%0d] got code=%0d tally=%b exp code=0 tally=%b", i, r_code[i], t_val[i], c[eb]); else passed++;
         if (i > 0) begin
            checks++; if (g_cyc[i] - g_cyc[i-1] != 4) $display("FAIL rr_gap[%0d] got %0d exp 4", i, g_cyc[i] - g_cyc[i-1]); else passed++;
         end
      end
      checks++; if (total_accepted !== CW'(model_acc)) $display("FAIL rr_accepted got %0d exp %0d", total_accepted, model_acc); else passed++;
   endtask

   task automatic test_invalid();
      logic [UW-1:0] tu [4];
      logic [NC-1:0] tc [4];
      logic [1:0] ec; int tg; bit ok; int eb;
      tu[0] = 6'h00; tc[0] = 4'b0001;
      tu[1] = 6'h05; tc[1] = 4'b0101;
      tu[2] = 6'h06; tc[2] = 4'b0000;
      tu[3] = 6'h00; tc[3] = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         eb = model_grant(NB'(1 << (i % NB)));
         ec = model_code(tu[i], tc[i]);
         model_apply(ec, tu[i]);
         run_one(i % NB, tu[i], tc[i], 0, tg, ok);
         checks++; if (!ok || r_code[0] !== ec || r_vec[0] !== NB'(1 << eb) || r_cyc[0] - tg != 2) $display("FAIL invalid[%0d] got code=%0d vec=%b dt=%0d exp code=%0d dt=2", i, r_code[0], r_vec[0], r_cyc[0] - tg, ec); else passed++;
         checks++; if (t_cyc.size() != 0) $display("FAIL invalid_tally[%0d] got %0d pulses exp 0", i, t_cyc.size()); else passed++;
      end
      checks++; if (total_accepted !== CW'(model_acc) || total_rejected !== CW'(model_rej)) $display("FAIL invalid_counters got %0d/%0d exp %0d/%0d", total_accepted, total_rejected, model_acc, model_rej); else passed++;
   endtask

   task automatic test_tally_stall();
      int tg; bit ok; int eb; logic [1:0] ec;
      logic [NC-1:0] cs [NB];
      logic [UW-1:0] us [NB];
      us[1] = 6'h21; cs[1] = 4'b0100;
      us[2] = 6'h22; cs[2] = 4'b1000;
      clear_mon();
      @(posedge clock); #1;
      set_req(1, us[1], cs[1]); set_req(2, us[2], cs[2]);
      req_valid = 4'b0110; mode = 1'b1; tally_busy = 1'b1;
      eb = model_grant(4'b0110);
      ec = model_code(us[eb], cs[eb]);
      model_apply(ec, us[eb]);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock); #1;
         if (g_cyc.size() != 0) begin ok = 1'b1; break; end
      end
      tg = g_cyc[0];
      @(posedge clock); #1;
      req_valid[eb] = 1'b0;
      mode = 1'b0;
      repeat (6) @(posedge clock);
      #1 tally_busy = 1'b0;
      repeat (15) @(posedge clock);
      #1;
      checks++; if (!ok || g_vec[0] !== NB'(1 << eb)) $display("FAIL stall_grant got %b exp booth %0d", g_vec[0], eb); else passed++;
      checks++; if (t_cyc.size() != 1 || t_cyc[0] - tg != 7 || t_val[0] !== cs[eb]) $display("FAIL stall_tally got n=%0d dt=%0d val=%b exp n=1 dt=7 val=%b", t_cyc.size(), t_cyc[0] - tg, t_val[0], cs[eb]); else passed++;
      checks++; if (r_cyc.size() != 1 || r_cyc[0] - tg != 8 || r_code[0] !== ec) $display("FAIL stall_rsp got n=%0d dt=%0d code=%0d exp n=1 dt=8 code=%0d", r_cyc.size(), r_cyc[0] - tg, r_code[0], ec); else passed++;
      checks++; if (g_cyc.size() != 1) $display("FAIL stall_no_more_grants got %0d grants exp 1", g_cyc.size()); else passed++;
      checks++; if (total_accepted !== CW'(model_acc)) $display("FAIL stall_accepted got %0d exp %0d", total_accepted, model_acc); else passed++;
      req_valid = '0;
   endtask

   task automatic test_clear_roll();
      int tg; bit ok; int eb; logic [1:0] ec;
      // clear_roll while voting is open is ignored
      @(posedge clock); #1 mode = 1'b1; clear_roll = 1'b1;
      repeat (2) @(posedge clock);
      #1 clear_roll = 1'b0;
      eb = model_grant(4'b0010);
      ec = model_code(6'h13, 4'b0010);
      model_apply(ec, 6'h13);
      run_one(1, 6'h13, 4'b0010, 0, tg, ok);
      checks++; if (!ok || r_code[0] !== ec || ec !== 2'd1) $display("FAIL clear_ignored got code=%0d exp %0d", r_code[0], ec); else passed++;
      // closed and idle: roll clears
      mode = 1'b0; clear_roll = 1'b1;
      @(posedge clock); #1 clear_roll = 1'b0;
      for (int i = 0; i < 2**UW; i++) model_roll[i] = 1'b0;
      eb = model_grant(4'b0010);
      ec = model_code(6'h13, 4'b0010);
      model_apply(ec, 6'h13);
      run_one(1, 6'h13, 4'b0010, 0, tg, ok);
      checks++; if (!ok || r_code[0] !== ec || ec !== 2'd0) $display("FAIL clear_honoured got code=%0d exp %0d", r_code[0], ec); else passed++;
   endtask

   task automatic test_mid_reset();
      int tg; bit ok; int eb; logic [1:0] ec;
      logic [NC-1:0] evc; logic [BW-1:0] evb;
      clear_mon();
      @(posedge clock); #1;
      set_req(3, 6'h11, 4'b1000);
      req_valid = 4'b1000; mode = 1'b1; tally_busy = 1'b1;
      for (int i = 0; i < 20 && g_cyc.size() == 0; i++) begin @(negedge clock); #1; end
      @(posedge clock); #1 req_valid = '0;
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || tally_inc !== '0 || rsp_valid !== '0 || req_ready !== '0) $display("FAIL midreset_outputs got busy=%b tally=%b rsp=%b rdy=%b exp all 0", busy, tally_inc, rsp_valid, req_ready); else passed++;
      checks++; if (total_accepted !== '0 || total_rejected !== '0 || vvpat_cand !== '0 || vvpat_booth !== '0) $display("FAIL midreset_regs got %0d/%0d/%b/%0d exp 0/0/0/0", total_accepted, total_rejected, vvpat_cand, vvpat_booth); else passed++;
      tally_busy = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      model_reset();
      checks++; if (t_cyc.size() != 0 || r_cyc.size() != 0) $display("FAIL midreset_lost got tally=%0d rsp=%0d exp 0/0", t_cyc.size(), r_cyc.size()); else passed++;
      eb = model_grant(4'b1000);
      ec = model_code(6'h11, 4'b0100);
      model_apply(ec, 6'h11);
      run_one(3, 6'h11, 4'b0100, 0, tg, ok);
      checks++; if (!ok || r_code[0] !== ec || ec !== 2'd0 || total_accepted !== CW'(model_acc)) $display("FAIL midreset_resubmit got code=%0d acc=%0d exp code=0 acc=%0d", r_code[0], total_accepted, model_acc); else passed++;
`ifdef EVM_VVPAT_EN
      evc = 4'b0100; evb = BW'(eb);
`else
      evc = '0; evb = '0;
`endif
      checks++; if (vvpat_cand !== evc || vvpat_booth !== evb) $display("FAIL midreset_vvpat got %b/%0d exp %b/%0d", vvpat_cand, vvpat_booth, evc, evb); else passed++;
   endtask

   task automatic test_saturation();
      int tg; bit ok; int bad; int eb; logic [1:0] ec; logic [UW-1:0] u;
      apply_reset();
      bad = 0;
      for (int i = 0; i < CNT_MAX + 5; i++) begin
         eb = model_grant(NB'(1 << (i % NB)));
         ec = model_code(6'h00, 4'b0001);
         model_apply(ec, 6'h00);
         run_one(i % NB, 6'h00, 4'b0001, 0, tg, ok);
         if (!ok) bad++;
      end
      checks++; if (total_rejected !== CW'(model_rej) || model_rej != CNT_MAX) $display("FAIL sat_rejected got %0d exp %0d", total_rejected, model_rej); else passed++;
      for (int i = 0; i < CNT_MAX + 5; i++) begin
         if (i % 63 == 0 && i > 0) begin
            mode = 1'b0; clear_roll = 1'b1;
            @(posedge clock); #1 clear_roll = 1'b0;
            for (int j = 0; j < 2**UW; j++) model_roll[j] = 1'b0;
         end
         u = UW'((i % 63) + 1);
         eb = model_grant(NB'(1 << (i % NB)));
         ec = model_code(u, 4'b0010);
         model_apply(ec, u);
         run_one(i % NB, u, 4'b0010, 0, tg, ok);
         if (!ok) bad++;
      end
      checks++; if (total_accepted !== CW'(model_acc) || model_acc != CNT_MAX) $display("FAIL sat_accepted got %0d exp %0d", total_accepted, model_acc); else passed++;
      checks++; if (total_rejected !== CW'(model_rej)) $display("FAIL sat_rejected_hold got %0d exp %0d", total_rejected, model_rej); else passed++;
      checks++; if (bad != 0) $display("FAIL sat_timeouts got %0d exp 0", bad); else passed++;
   endtask

   task automatic test_random();
      logic [UW-1:0] u [NB];
      logic [NC-1:0] c [NB];
      logic [NB-1:0] pend;
      logic [1:0]    ec [$];
      logic [NC-1:0] ok_cand [$];
      int            eb [$];
      bit ok; int n; int gap;
      for (int r = 0; r < 30; r++) begin
         clear_mon(); ec.delete(); ok_cand.delete(); eb.delete();
         @(posedge clock); #1;
         pend = NB'($urandom_range(1, (1 << NB) - 1));
         for (int b = 0; b < NB; b++) begin
            u[b] = UW'($urandom_range(0, 12));
            if ($urandom_range(0, 9) < 7) c[b] = NC'(1 << $urandom_range(0, NC - 1));
            else c[b] = NC'($urandom_range(0, (1 << NC) - 1));
            set_req(b, u[b], c[b]);
         end
         mode = 1'b1; req_valid = pend;
         serve(1'b1, ok);
         n = $countones(pend);
         for (int i = 0; i < n; i++) begin
            int w;
            w = model_grant(pend);
            pend[w] = 1'b0;
            eb.push_back(w);
            ec.push_back(model_code(u[w], c[w]));
            if (ec[i] == 2'd0) ok_cand.push_back(c[w]);
            model_apply(ec[i], u[w]);
         end
         checks++; if (!ok || g_cyc.size() != n || r_cyc.size() != n) $display("FAIL rand[%0d]_count got g=%0d r=%0d ok=%0d exp %0d", r, g_cyc.size(), r_cyc.size(), ok, n); else passed++;
         for (int i = 0; i < n && i < g_cyc.size() && i < r_cyc.size(); i++) begin
            checks++; if (g_vec[i] !== NB'(1 << eb[i]) || r_vec[i] !== NB'(1 << eb[i]) || r_code[i] !== ec[i]) $display("FAIL rand[%0d]_txn[%0d] got grant=%b rsp=%b code=%0d exp booth %0d code=%0d", r, i, g_vec[i], r_vec[i], r_code[i], eb[i], ec[i]); else passed++;
            if (i > 0) begin
               gap = (ec[i-1] == 2'd0) ? 4 : 3;
               checks++; if (g_cyc[i] - g_cyc[i-1] < gap) $display("FAIL rand[%0d]_gap[%0d] got %0d exp >= %0d", r, i, g_cyc[i] - g_cyc[i-1], gap); else passed++;
            end
         end
         checks++; if (t_val.size() != ok_cand.size() || (ok_cand.size() > 0 && t_val != ok_cand)) $display("FAIL rand[%0d]_tally got %0d pulses exp %0d", r, t_val.size(), ok_cand.size()); else passed++;
         checks++; if (total_accepted !== CW'(model_acc) || total_rejected !== CW'(model_rej)) $display("FAIL rand[%0d]_counters got %0d/%0d exp %0d/%0d", r, total_accepted, total_rejected, model_acc, model_rej); else passed++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_vote();
      test_double_vote();
      test_round_robin();
      test_invalid();
      test_tally_stall();
      test_clear_roll();
      test_mid_reset();
      test_saturation();
      test_random();
      checks++; if (multi_err != 0) $display("FAIL onehot_pulses got %0d bad cycles exp 0", multi_err); else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got no finish exp finish");
      $fatal(1, "timeout");
   end

endmodule
